// File: rtl/vme_system_controller_pkg.sv
// Shared definitions for the slot-1 VME system controller: bus signal levels,
// arbiter state encoding and the bus request/grant level type.
package vme_system_controller_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam int BUS_LEVELS = 4;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_BUSY   = 2'd2,
        ARB_SETTLE = 2'd3
    } arb_state_t;

    // Active-low bus grant pattern with only the selected level driven.
    function automatic logic [BUS_LEVELS-1:0] grant_mask(input level_t lvl);
        logic [BUS_LEVELS-1:0] mask;
        mask      = {BUS_LEVELS{INACTIVE}};
        mask[lvl] = ACTIVE;
        return mask;
    endfunction

endpackage

// File: rtl/vme_system_controller_if.sv
// VME arbitration and data-transfer strobes seen by the system controller.
// The slave modport is the controller's view; master is the bus side.
interface vme_system_controller_if;
    import vme_system_controller_pkg::*;

    logic [BUS_LEVELS-1:0] vme_br_sync;
    logic                  vme_bbsy_sync;
    logic [1:0]            vme_ds_sync;
    logic                  vme_dtack_sync;
    logic                  vme_berr_sync;
    logic [BUS_LEVELS-1:0] vme_bg_out;
    logic                  vme_berr_out;

    modport master (
        output vme_br_sync,
        output vme_bbsy_sync,
        output vme_ds_sync,
        output vme_dtack_sync,
        output vme_berr_sync,
        input  vme_bg_out,
        input  vme_berr_out
    );

    modport slave (
        input  vme_br_sync,
        input  vme_bbsy_sync,
        input  vme_ds_sync,
        input  vme_dtack_sync,
        input  vme_berr_sync,
        output vme_bg_out,
        output vme_berr_out
    );

endinterface

// File: rtl/vme_system_controller_bus_timer.sv
// Global VME bus timer: raises BERR when a data strobe stays unanswered for
// TIMEOUT_CYCLES clocks, holding it until both strobes are released.
module vme_bus_timer
    import vme_system_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800,
    parameter int TIMER_WIDTH    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ds_sync,
    input  logic       dtack_sync,
    input  logic       berr_sync,
    output logic       berr_out,
    output logic       timeout_event
);

    localparam logic [TIMER_WIDTH-1:0] TERMINAL = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count;
    logic                   ds_active;
    logic                   count_enable;

    assign ds_active    = (ds_sync[0] == ACTIVE) || (ds_sync[1] == ACTIVE);
    assign count_enable = ds_active && (dtack_sync == INACTIVE) && (berr_sync == INACTIVE);

    // The counter parks at TERMINAL; the edge that finds it there fires BERR,
    // so a DTACK arriving on that same edge still suppresses the timeout.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            berr_out      <= INACTIVE;
            timeout_event <= 1'b0;
        end else begin
            timeout_event <= 1'b0;
            if (!ds_active) begin
                count    <= '0;
                berr_out <= INACTIVE;
            end else if (count_enable) begin
                if (count != TERMINAL) begin
                    count <= count + TIMER_WIDTH'(1);
                end else if (berr_out == INACTIVE) begin
                    berr_out      <= ACTIVE;
                    timeout_event <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vme_system_controller.sv
// Slot-1 VME system controller: round-robin arbiter for BR3..BR0 driving the
// BG daisy chain, plus the global bus timer.
module vme_system_controller
    import vme_system_controller_pkg::*;
#(
    parameter int NUM_LEVELS     = BUS_LEVELS,
    parameter int TIMEOUT_CYCLES = 800,
    parameter int TIMER_WIDTH    = 10,
    parameter int GRANT_TIMEOUT  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arb_enable,
    vme_system_controller_if.slave  bus,
    output level_t                  grant_level,
    output logic                    bus_owned,
    output logic                    timeout_event
);

    localparam int WAIT_WIDTH = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(GRANT_TIMEOUT - 1);

    arb_state_t              state;
    level_t                  last_level;
    logic [WAIT_WIDTH-1:0]   wait_cnt;
    logic [NUM_LEVELS-1:0]   req;
    logic                    bbsy_active;
    logic                    pick_valid;
    level_t                  pick_level;

    assign req         = ~bus.vme_br_sync;
    assign bbsy_active = (bus.vme_bbsy_sync == ACTIVE);

    // Round-robin search: last_level-1 first, last_level itself last. The
    // loop walks from furthest to nearest so the nearest request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_level = last_level;
        for (int i = NUM_LEVELS; i >= 1; i--) begin
            if (req[last_level - level_t'(i)]) begin
                pick_valid = 1'b1;
                pick_level = last_level - level_t'(i);
            end
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ARB_IDLE;
            bus.vme_bg_out <= '1;
            grant_level    <= '0;
            last_level     <= '0;
            bus_owned      <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    bus.vme_bg_out <= '1;
                    if (arb_enable && pick_valid && !bbsy_active) begin
                        grant_level    <= pick_level;
                        bus.vme_bg_out <= grant_mask(pick_level);
                        wait_cnt       <= '0;
                        state          <= ARB_GRANT;
                    end
                end

                ARB_GRANT: begin
                    if (bbsy_active) begin
                        bus.vme_bg_out <= '1;
                        bus_owned      <= 1'b1;
                        last_level     <= grant_level;
                        state          <= ARB_BUSY;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Requester withdrew before taking the bus.
                        bus.vme_bg_out <= '1;
                        state          <= ARB_SETTLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
                    end
                end

                ARB_BUSY: begin
                    if (!bbsy_active) begin
                        bus_owned <= 1'b0;
                        state     <= ARB_SETTLE;
                    end
                end

                ARB_SETTLE: begin
                    bus.vme_bg_out <= '1;
                    state          <= ARB_IDLE;
                end

                default: begin
                    bus.vme_bg_out <= '1;
                    bus_owned      <= 1'b0;
                    state          <= ARB_IDLE;
                end
            endcase
        end
    end

    vme_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_bus_timer (
        .clock         (clock),
        .reset         (reset),
        .ds_sync       (bus.vme_ds_sync),
        .dtack_sync    (bus.vme_dtack_sync),
        .berr_sync     (bus.vme_berr_sync),
        .berr_out      (bus.vme_berr_out),
        .timeout_event (timeout_event)
    );

endmodule
